// File: rtl/bp_me_pkg.sv
//------------------------------------------------------------------------------
// Module   : bp_me_pkg
// Brief    : Shared memory-endpoint types: BedRock uncached mem message,
//            cfg-bus local address layout, LCE/CCE modes, cfg address map
//            and the cfg endpoint decode target.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package bp_me_pkg;

  // Processor configurations known to this slice
  typedef enum logic [0:0] {
    e_bp_default_cfg = 1'b0
  } bp_params_e;

  localparam int paddr_width_gp     = 40;
  localparam int tile_id_width_gp   = 6;
  localparam int cfg_dev_width_gp   = 4;
  localparam int cfg_addr_width_gp  = 20;
  localparam int nonlocal_width_gp  = paddr_width_gp - tile_id_width_gp
                                      - cfg_dev_width_gp - cfg_addr_width_gp;
  localparam int payload_width_gp   = 16;
  localparam int data_width_gp      = 64;

  // cfg device id and cfg-space address map
  localparam logic [cfg_dev_width_gp-1:0]  cfg_dev_gp                 = 4'h2;
  localparam logic [cfg_addr_width_gp-1:0] cfg_reg_freeze_gp          = 20'h00008;
  localparam logic [cfg_addr_width_gp-1:0] cfg_reg_icache_mode_gp     = 20'h00010;
  localparam logic [cfg_addr_width_gp-1:0] cfg_reg_dcache_mode_gp     = 20'h00018;
  localparam logic [cfg_addr_width_gp-1:0] cfg_reg_cce_mode_gp        = 20'h00020;
  localparam logic [cfg_addr_width_gp-1:0] cfg_reg_hio_mask_gp        = 20'h00028;
  localparam logic [cfg_addr_width_gp-1:0] cfg_reg_scratch_gp         = 20'h00030;
  localparam logic [cfg_addr_width_gp-1:0] cfg_mem_base_cce_ucode_gp  = 20'h08000;

  typedef enum logic [3:0] {
    e_bedrock_mem_rd    = 4'd0,
    e_bedrock_mem_wr    = 4'd1,
    e_bedrock_mem_uc_rd = 4'd2,
    e_bedrock_mem_uc_wr = 4'd3,
    e_bedrock_mem_pre   = 4'd4,
    e_bedrock_mem_amo   = 4'd5
  } bp_bedrock_mem_type_e;

  typedef enum logic [1:0] {
    e_lce_mode_uncached = 2'd0,
    e_lce_mode_normal   = 2'd1,
    e_lce_mode_nonspec  = 2'd2
  } bp_lce_mode_e;

  typedef enum logic [0:0] {
    e_cce_mode_uncached = 1'b0,
    e_cce_mode_normal   = 1'b1
  } bp_cce_mode_e;

  typedef struct packed {
    logic [payload_width_gp-1:0] payload;
    logic [2:0]                  size;
    logic [paddr_width_gp-1:0]   addr;
    bp_bedrock_mem_type_e        msg_type;
  } bp_bedrock_cce_mem_header_s;

  typedef struct packed {
    logic [data_width_gp-1:0]   data;
    bp_bedrock_cce_mem_header_s header;
  } bp_bedrock_cce_mem_msg_s;

  localparam int cce_mem_msg_width_gp = $bits(bp_bedrock_cce_mem_msg_s);

  // Physical address as seen on the cfg bus
  typedef struct packed {
    logic [nonlocal_width_gp-1:0] nonlocal;
    logic [tile_id_width_gp-1:0]  tile;
    logic [cfg_dev_width_gp-1:0]  dev;
    logic [cfg_addr_width_gp-1:0] addr;
  } bp_local_addr_s;

  typedef enum logic [2:0] {
    REG_FREEZE  = 3'd0,
    REG_ICACHE  = 3'd1,
    REG_DCACHE  = 3'd2,
    REG_CCE     = 3'd3,
    REG_HIO     = 3'd4,
    REG_SCRATCH = 3'd5,
    UCODE       = 3'd6,
    UNMAPPED    = 3'd7
  } bp_cfg_ep_target_e;

  // Physical address width for a processor configuration
  function automatic int cfg_paddr_width(input bp_params_e cfg);
    case (cfg)
      e_bp_default_cfg: return paddr_width_gp;
      default:          return paddr_width_gp;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/bp_me_cfg_addr_decode.sv
//------------------------------------------------------------------------------
// Module   : bp_me_cfg_addr_decode
// Brief    : Combinational cfg address decode: local address + tile id ->
//            endpoint target and CCE ucode RAM index.
//            BP_CFG_EP_SCRATCH_EN maps the scratch register; otherwise its
//            address decodes as UNMAPPED.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module bp_me_cfg_addr_decode
  import bp_me_pkg::*;
#(
  parameter int paddr_width_p         = paddr_width_gp,
  parameter int inst_ram_addr_width_p = 8
) (
  input  logic [paddr_width_p-1:0]         addr_i,
  input  logic [tile_id_width_gp-1:0]      tile_id_i,
  output bp_cfg_ep_target_e                target_o,
  output logic [inst_ram_addr_width_p-1:0] ucode_addr_o
);

  bp_local_addr_s w_local;
  logic           w_hit;

  assign w_local      = addr_i;
  assign w_hit        = (w_local.nonlocal == '0)
                      & (w_local.tile == tile_id_i)
                      & (w_local.dev == cfg_dev_gp);
  // ucode entries are 64-bit, so the index starts at byte-address bit 3
  assign ucode_addr_o = w_local.addr[3+:inst_ram_addr_width_p];

  // Anything that misses this tile/device, or hits a hole, is UNMAPPED
  always_comb begin
    target_o = UNMAPPED;
    if (w_hit) begin
      if (w_local.addr >= cfg_mem_base_cce_ucode_gp) begin
        target_o = UCODE;
      end else begin
        case (w_local.addr)
          cfg_reg_freeze_gp:      target_o = REG_FREEZE;
          cfg_reg_icache_mode_gp: target_o = REG_ICACHE;
          cfg_reg_dcache_mode_gp: target_o = REG_DCACHE;
          cfg_reg_cce_mode_gp:    target_o = REG_CCE;
          cfg_reg_hio_mask_gp:    target_o = REG_HIO;
`ifdef BP_CFG_EP_SCRATCH_EN
          cfg_reg_scratch_gp:     target_o = REG_SCRATCH;
`endif
          default:                target_o = UNMAPPED;
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/bp_me_cfg_endpoint.sv
//------------------------------------------------------------------------------
// Module   : bp_me_cfg_endpoint
// Brief    : Tile-side cfg endpoint. Accepts one uncached mem command at a
//            time, updates/reads the freeze, cache mode, CCE mode and HIO
//            mask registers or the CCE ucode RAM, and returns exactly one
//            response per command (the loader's credit).
//            BP_CFG_EP_SCRATCH_EN adds a 64-bit R/W scratch register.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module bp_me_cfg_endpoint
  import bp_me_pkg::*;
#(
  parameter bp_params_e  bp_params_p           = e_bp_default_cfg,
  parameter int          inst_ram_addr_width_p = 8,
  parameter logic        freeze_reset_p        = 1'b1,
  parameter logic [63:0] hio_mask_reset_p      = 64'h0
) (
  input  logic                             clk_i,
  input  logic                             reset_n_i,
  input  logic [tile_id_width_gp-1:0]      tile_id_i,
  input  logic [cce_mem_msg_width_gp-1:0]  io_cmd_i,
  input  logic                             io_cmd_v_i,
  output logic                             io_cmd_ready_o,
  output logic [cce_mem_msg_width_gp-1:0]  io_resp_o,
  output logic                             io_resp_v_o,
  input  logic                             io_resp_yumi_i,
  output logic                             freeze_o,
  output bp_lce_mode_e                     icache_mode_o,
  output bp_lce_mode_e                     dcache_mode_o,
  output bp_cce_mode_e                     cce_mode_o,
  output logic [63:0]                      hio_mask_o,
  output logic                             ucode_v_o,
  output logic                             ucode_w_o,
  output logic [inst_ram_addr_width_p-1:0] ucode_addr_o,
  output logic [63:0]                      ucode_data_o,
  input  logic [63:0]                      ucode_data_i
);

  localparam int c_paddr_width = cfg_paddr_width(bp_params_p);

  typedef enum logic [1:0] {
    e_ready    = 2'd0,
    e_ucode_rd = 2'd1,
    e_resp     = 2'd2
  } state_e;

  state_e                  r_state;
  logic                    r_resp_v;
  bp_bedrock_cce_mem_msg_s r_resp;
  bp_bedrock_cce_mem_msg_s w_cmd;
  bp_cfg_ep_target_e       w_target;
  logic                    w_accept;
  logic                    w_is_rd;
  logic                    w_is_wr;
  logic [63:0]             w_rd_data;

  logic                    r_freeze;
  bp_lce_mode_e            r_icache_mode;
  bp_lce_mode_e            r_dcache_mode;
  bp_cce_mode_e            r_cce_mode;
  logic [63:0]             r_hio_mask;
`ifdef BP_CFG_EP_SCRATCH_EN
  logic [63:0]             r_scratch;
`endif

  assign w_cmd          = io_cmd_i;
  assign io_cmd_ready_o = (r_state == e_ready);
  assign w_accept       = io_cmd_v_i & io_cmd_ready_o;
  assign w_is_rd        = (w_cmd.header.msg_type == e_bedrock_mem_uc_rd);
  assign w_is_wr        = (w_cmd.header.msg_type == e_bedrock_mem_uc_wr);

  bp_me_cfg_addr_decode #(
    .paddr_width_p         (c_paddr_width),
    .inst_ram_addr_width_p (inst_ram_addr_width_p)
  ) u_decode (
    .addr_i       (w_cmd.header.addr),
    .tile_id_i    (tile_id_i),
    .target_o     (w_target),
    .ucode_addr_o (ucode_addr_o)
  );

  // The ucode RAM is strobed directly in the accept cycle
  assign ucode_v_o    = w_accept & (w_target == UCODE) & (w_is_rd | w_is_wr);
  assign ucode_w_o    = w_accept & (w_target == UCODE) & w_is_wr;
  assign ucode_data_o = w_cmd.data;

  // Current value of the addressed register, zero-extended; holes read 0
  always_comb begin
    w_rd_data = '0;
    case (w_target)
      REG_FREEZE:  w_rd_data = {63'b0, r_freeze};
      REG_ICACHE:  w_rd_data = 64'(r_icache_mode);
      REG_DCACHE:  w_rd_data = 64'(r_dcache_mode);
      REG_CCE:     w_rd_data = 64'(r_cce_mode);
      REG_HIO:     w_rd_data = r_hio_mask;
`ifdef BP_CFG_EP_SCRATCH_EN
      REG_SCRATCH: w_rd_data = r_scratch;
`endif
      default:     w_rd_data = '0;
    endcase
  end

  // Config registers update on the accept edge of a decoded uc_wr
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_freeze      <= freeze_reset_p;
      r_icache_mode <= e_lce_mode_uncached;
      r_dcache_mode <= e_lce_mode_uncached;
      r_cce_mode    <= e_cce_mode_uncached;
      r_hio_mask    <= hio_mask_reset_p;
`ifdef BP_CFG_EP_SCRATCH_EN
      r_scratch     <= '0;
`endif
    end else if (w_accept && w_is_wr) begin
      case (w_target)
        REG_FREEZE:  r_freeze      <= w_cmd.data[0];
        REG_ICACHE:  r_icache_mode <= bp_lce_mode_e'(w_cmd.data[$bits(bp_lce_mode_e)-1:0]);
        REG_DCACHE:  r_dcache_mode <= bp_lce_mode_e'(w_cmd.data[$bits(bp_lce_mode_e)-1:0]);
        REG_CCE:     r_cce_mode    <= bp_cce_mode_e'(w_cmd.data[$bits(bp_cce_mode_e)-1:0]);
        REG_HIO:     r_hio_mask    <= w_cmd.data;
`ifdef BP_CFG_EP_SCRATCH_EN
        REG_SCRATCH: r_scratch     <= w_cmd.data;
`endif
        default:     ;
      endcase
    end
  end

  // One command in flight: accept, optionally wait for ucode data, then hold the response until taken
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state  <= e_ready;
      r_resp_v <= 1'b0;
      r_resp   <= '0;
    end else begin
      case (r_state)
        e_ready: begin
          if (w_accept) begin
            r_resp.header <= w_cmd.header;
            r_resp.data   <= w_is_rd ? w_rd_data : '0;
            if (w_is_rd && (w_target == UCODE)) begin
              r_state <= e_ucode_rd;
            end else begin
              r_state  <= e_resp;
              r_resp_v <= 1'b1;
            end
          end
        end
        e_ucode_rd: begin
          r_resp.data <= ucode_data_i;
          r_state     <= e_resp;
          r_resp_v    <= 1'b1;
        end
        e_resp: begin
          if (io_resp_yumi_i) begin
            r_state  <= e_ready;
            r_resp_v <= 1'b0;
          end
        end
        default: begin
          r_state  <= e_ready;
          r_resp_v <= 1'b0;
        end
      endcase
    end
  end

  assign io_resp_o     = r_resp;
  assign io_resp_v_o   = r_resp_v;
  assign freeze_o      = r_freeze;
  assign icache_mode_o = r_icache_mode;
  assign dcache_mode_o = r_dcache_mode;
  assign cce_mode_o    = r_cce_mode;
  assign hio_mask_o    = r_hio_mask;

`ifndef SYNTHESIS
  // A consumer may only take a response that is being offered
  yumi_without_valid_a : assert property (
    @(posedge clk_i) disable iff (!reset_n_i) io_resp_yumi_i |-> io_resp_v_o
  );
`endif

endmodule

`default_nettype wire
